chacha_block_gen: RTL and testbench

- Keystream block producer: the other end of the block-counter interface.
- On `start`, samples `key`, `nonce` and the 32-bit block `counter` word, then runs the ChaCha20 block function, one half-round per cycle (4 quarter-rounds in parallel).
- Presents a 512-bit keystream block and holds `block_ready` high until the consumer acknowledges it.
- The rising edge of `block_ready` is what advances the upstream block counter.

---
 rtl/chacha_pkg.sv | 40 ++++
 rtl/chacha_quarter_round.sv | 39 +++
 rtl/chacha_block_gen.sv | 154 +++++++++++++++
 tb/tb_chacha_block_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, constants and quarter-round index tables for chacha_block_gen
package chacha_pkg;

    typedef logic [31:0] word_t;

    // Word 0 in bits [31:0], word 15 in bits [511:480].
    typedef word_t [15:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_t;

    // "expand 32-byte k", word 0 is the lowest element.
    localparam logic [3:0][31:0] SIGMA = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    // Entry [qr*4 + pos] is the state word feeding operand pos (a,b,c,d) of quarter-round qr.
    localparam logic [15:0][3:0] COL_IDX = {
        4'd15, 4'd11, 4'd7, 4'd3,
        4'd14, 4'd10, 4'd6, 4'd2,
        4'd13, 4'd9,  4'd5, 4'd1,
        4'd12, 4'd8,  4'd4, 4'd0
    };

    localparam logic [15:0][3:0] DIAG_IDX = {
        4'd14, 4'd9,  4'd4, 4'd3,
        4'd13, 4'd8,  4'd7, 4'd2,
        4'd12, 4'd11, 4'd6, 4'd1,
        4'd15, 4'd10, 4'd5, 4'd0
    };

    function automatic logic [3:0] qr_index(input logic diag, input int qr, input int pos);
        return diag ? DIAG_IDX[qr*4 + pos] : COL_IDX[qr*4 + pos];
    endfunction

endpackage

// File: rtl/chacha_quarter_round.sv
// rtl/chacha_quarter_round.sv - combinational ChaCha quarter-round
module chacha_quarter_round
    import chacha_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    input  word_t c_i,
    input  word_t d_i,
    output word_t a_o,
    output word_t b_o,
    output word_t c_o,
    output word_t d_o
);

    word_t a1, b1, c1, d1, dx1, bx1;
    word_t a2, b2, c2, d2, dx2, bx2;

    // first half: rotate by 16 then 12
    assign a1  = a_i + b_i;
    assign dx1 = d_i ^ a1;
    assign d1  = {dx1[15:0], dx1[31:16]};
    assign c1  = c_i + d1;
    assign bx1 = b_i ^ c1;
    assign b1  = {bx1[19:0], bx1[31:20]};

    // second half: rotate by 8 then 7
    assign a2  = a1 + b1;
    assign dx2 = d1 ^ a2;
    assign d2  = {dx2[23:0], dx2[31:24]};
    assign c2  = c1 + d2;
    assign bx2 = b1 ^ c2;
    assign b2  = {bx2[24:0], bx2[31:25]};

    assign a_o = a2;
    assign b_o = b2;
    assign c_o = c2;
    assign d_o = d2;

endmodule

// File: rtl/chacha_block_gen.sv
// rtl/chacha_block_gen.sv - ChaCha20 keystream block producer, one half-round per cycle (optional CHACHA_KS_ZEROIZE_EN)
module chacha_block_gen
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
    input  logic         start,
    input  logic         ks_ack,
    output logic         busy,
    output logic         block_ready,
    output logic [511:0] keystream,
    output logic [31:0]  blocks_produced
);

    localparam int NUM_ROUNDS = 2 * DOUBLE_ROUNDS;
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    fsm_t          state_q, state_d;
    state_t        init_q, init_d;
    state_t        work_q, work_d;
    state_t        ks_q, ks_d;
    logic [RW-1:0] round_q, round_d;
    logic          ready_q, ready_d;
    word_t         count_q, count_d;

    state_t        load_state;
    word_t         qr_in  [4][4];
    word_t         qr_out [4][4];

    // initial state image assembled from constants, key, counter and nonce
    always_comb begin
        load_state = '0;
        for (int i = 0; i < 4; i++) begin
            load_state[i] = SIGMA[i];
        end
        for (int i = 0; i < 8; i++) begin
            load_state[4 + i] = key[32*i +: 32];
        end
        load_state[12] = counter;
        for (int i = 0; i < 3; i++) begin
            load_state[13 + i] = nonce[32*i +: 32];
        end
    end

    // gather quarter-round operands: even rounds use columns, odd rounds diagonals
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            for (int p = 0; p < 4; p++) begin
                qr_in[q][p] = work_q[qr_index(round_q[0], q, p)];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_qr
        chacha_quarter_round u_qr (
            .a_i (qr_in[g][0]),
            .b_i (qr_in[g][1]),
            .c_i (qr_in[g][2]),
            .d_i (qr_in[g][3]),
            .a_o (qr_out[g][0]),
            .b_o (qr_out[g][1]),
            .c_o (qr_out[g][2]),
            .d_o (qr_out[g][3])
        );
    end

    // next-state and datapath control
    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        work_d  = work_q;
        ks_d    = ks_q;
        round_d = round_q;
        ready_d = ready_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    init_d  = load_state;
                    work_d  = load_state;
                    round_d = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                for (int q = 0; q < 4; q++) begin
                    for (int p = 0; p < 4; p++) begin
                        work_d[qr_index(round_q[0], q, p)] = qr_out[q][p];
                    end
                end
                round_d = round_q + RW'(1);
                if (round_q == LAST_ROUND) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                for (int i = 0; i < 16; i++) begin
                    ks_d[i] = work_q[i] + init_q[i];
                end
                ready_d = 1'b1;
                count_d = count_q + 32'd1;
                state_d = DONE;
            end
            DONE: begin
                if (ks_ack) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
`ifdef CHACHA_KS_ZEROIZE_EN
                    ks_d    = '0;
                    work_d  = '0;
                    init_d  = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers; reset abandons any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= '0;
            work_q  <= '0;
            ks_q    <= '0;
            round_q <= '0;
            ready_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            work_q  <= work_d;
            ks_q    <= ks_d;
            round_q <= round_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign block_ready     = ready_q;
    assign keystream       = ks_q;
    assign blocks_produced = count_q;

endmodule

// File: tb/tb_chacha_block_gen.sv
// tb/tb_chacha_block_gen.sv - self-checking bench for chacha_block_gen against a software ChaCha20 model
module tb_chacha_block_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  counter;
    logic         start;
    logic         ks_ack;
    logic         busy;
    logic         block_ready;
    logic [511:0] keystream;
    logic [31:0]  blocks_produced;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chacha_block_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key             (key),
        .nonce           (nonce),
        .counter         (counter),
        .start           (start),
        .ks_ack          (ks_ack),
        .busy            (busy),
        .block_ready     (block_ready),
        .keystream       (keystream),
        .blocks_produced (blocks_produced)
    );

    typedef struct {
        logic [255:0] k;
        logic [95:0]  n;
        logic [31:0]  c;
        logic [511:0] exp_ks;
    } vec_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [15:0][31:0] qr(input logic [15:0][31:0] x, input int a, input int b, input int c, input int d);
        logic [15:0][31:0] y;
        y = x;
        y[a] = y[a] + y[b]; y[d] = rotl(y[d] ^ y[a], 16);
        y[c] = y[c] + y[d]; y[b] = rotl(y[b] ^ y[c], 12);
        y[a] = y[a] + y[b]; y[d] = rotl(y[d] ^ y[a], 8);
        y[c] = y[c] + y[d]; y[b] = rotl(y[b] ^ y[c], 7);
        return y;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        logic [15:0][31:0] s;
        logic [15:0][31:0] x;
        logic [511:0]      o;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
        x = s;
        for (int r = 0; r < 10; r++) begin
            x = qr(x, 0, 4, 8, 12);  x = qr(x, 1, 5, 9, 13);
            x = qr(x, 2, 6, 10, 14); x = qr(x, 3, 7, 11, 15);
            x = qr(x, 0, 5, 10, 15); x = qr(x, 1, 6, 11, 12);
            x = qr(x, 2, 7, 8, 13);  x = qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where block_ready was first seen.
    task automatic run_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c, input bit disturb);
        int lat;
        key = k; nonce = n; counter = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        lat = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (disturb && cyc == 5) begin
                start = 1'b1; counter = 32'd7; key = ~k; ks_ack = 1'b1;
            end
            if (disturb && cyc == 6) begin
                start = 1'b0; ks_ack = 1'b0;
            end
            @(posedge clk); #1;
            if (block_ready === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        chk("ready_latency", lat, 21);
    endtask

    task automatic ack_block(input bit with_start);
        ks_ack = 1'b1;
        start  = with_start;
        @(posedge clk); #1;
        ks_ack = 1'b0;
        start  = 1'b0;
        chk("ready_cleared", block_ready, 0);
        chk("idle_after_ack", busy, 0);
    endtask

    vec_t         vecs [6];
    logic [255:0] rfc_k;
    logic [95:0]  rfc_n;
    logic [511:0] rfc_exp;
    logic [511:0] held;
    logic [255:0] rk;
    logic [31:0]  bp_exp;
    bit           stable;

    initial begin
        rst_n = 1'b0; key = '0; nonce = '0; counter = '0; start = 1'b0; ks_ack = 1'b0;

        for (int i = 0; i < 32; i++) rfc_k[8*i +: 8] = 8'(i);
        rfc_n   = {32'h00000000, 32'h4a000000, 32'h09000000};
        rfc_exp = ref_block(rfc_k, rfc_n, 32'd1);

        vecs[0] = '{rfc_k, rfc_n, 32'd1, rfc_exp};
        vecs[1] = '{256'h0, 96'h0, 32'd0, ref_block(256'h0, 96'h0, 32'd0)};
        for (int i = 2; i < 6; i++) begin
            for (int w = 0; w < 8; w++) vecs[i].k[32*w +: 32] = $urandom;
            vecs[i].n = {$urandom, $urandom, $urandom};
            vecs[i].c = $urandom;
            vecs[i].exp_ks = ref_block(vecs[i].k, vecs[i].n, vecs[i].c);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_ready", block_ready, 0);
        chk("reset_keystream", keystream, 0);
        chk("reset_blocks", blocks_produced, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RFC 8439 vector, long hold, then ack with a coincident start that must be ignored
        run_block(rfc_k, rfc_n, 32'd1, 1'b0);
        chk("rfc_word0", keystream[31:0], 32'he4e7f110);
        chk("rfc_word1", keystream[63:32], 32'h15593bd1);
        chk("rfc_word15", keystream[511:480], 32'h4e3c50a2);
        chk("rfc_full", keystream, rfc_exp);
        chk("rfc_blocks", blocks_produced, 1);
        held = keystream;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (block_ready !== 1'b1 || keystream !== held) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        ack_block(1'b1);
`ifdef CHACHA_KS_ZEROIZE_EN
        chk("ks_after_ack", keystream, 0);
`else
        chk("ks_after_ack", keystream[31:0], 32'he4e7f110);
`endif
        @(posedge clk); #1;
        chk("start_with_ack_ignored", busy, 0);

        // start, ks_ack and counter disturbed mid-round must not affect the block
        run_block(rfc_k, rfc_n, 32'd1, 1'b1);
        chk("disturb_ks", keystream, rfc_exp);
        chk("disturb_blocks", blocks_produced, 2);
        ack_block(1'b0);

        // asynchronous reset in the middle of ROUND
        key = rfc_k; nonce = rfc_n; counter = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_ready", block_ready, 0);
        chk("midreset_ks", keystream, 0);
        chk("midreset_blocks", blocks_produced, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(rfc_k, rfc_n, 32'd1, 1'b0);
        chk("postreset_ks", keystream, rfc_exp);
        chk("postreset_blocks", blocks_produced, 1);
        ack_block(1'b0);
        bp_exp = 32'd1;

        // table of vectors
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].k, vecs[i].n, vecs[i].c, 1'b0);
            chk($sformatf("vec%0d_ks", i), keystream, vecs[i].exp_ks);
            bp_exp = bp_exp + 32'd1;
            chk($sformatf("vec%0d_blocks", i), blocks_produced, bp_exp);
            ack_block(1'b0);
        end

        // block counter wrap and blocks_produced wrap
        force dut.count_q = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release dut.count_q;
        @(posedge clk); #1;
        chk("preload_blocks", blocks_produced, 32'hFFFFFFFF);
        for (int w = 0; w < 8; w++) rk[32*w +: 32] = $urandom;
        run_block(rk, rfc_n, 32'hFFFFFFFF, 1'b0);
        chk("wrap_ks", keystream, ref_block(rk, rfc_n, 32'hFFFFFFFF));
        chk("wrap_blocks", blocks_produced, 0);
        ack_block(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
